// File: rtl/demux_memoria1x4_4bits_if.sv
// Bundle between the single-stream source and the four-lane registered demux.
// The master drives the word stream and lane control; the slave returns lane state.
interface demux_memoria1x4_4bits_if #(
  parameter int DATA_W = 4
);
  logic [1:0]        selector;
  logic              auto_sel;
  logic              valid_input;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  logic [DATA_W-1:0] data_out3;
  logic              valid_out0;
  logic              valid_out1;
  logic              valid_out2;
  logic              valid_out3;
  logic [1:0]        lane_ptr;
  logic              frame_done;

  modport master (
    output selector, auto_sel, valid_input, data_in,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  lane_ptr, frame_done
  );

  modport slave (
    input  selector, auto_sel, valid_input, data_in,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output lane_ptr, frame_done
  );
endinterface

// File: rtl/demux_memoria1x4_4bits.sv
// Registered 1-to-4 demux: each accepted word lands in one lane's holding register
// with a one-cycle valid pulse; lane chosen by selector or a round-robin pointer.
module demux_memoria1x4_4bits #(
  parameter int DATA_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  demux_memoria1x4_4bits_if.slave   bus
);
  logic [DATA_W-1:0] data_reg [4];
  logic [3:0]        valid_reg;
  logic [1:0]        lane_ptr_reg;
  logic              frame_done_reg;
  logic [1:0]        dest;
  logic              accept;

  // The pointer is forced to 0 outside auto mode, so a rising auto_sel starts at lane 0.
  always_comb begin
    accept = bus.valid_input;
    dest   = bus.auto_sel ? lane_ptr_reg : bus.selector;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (!reset_L) begin
        data_reg[gi]  <= '0;
        valid_reg[gi] <= 1'b0;
      end else begin
        valid_reg[gi] <= accept && (dest == 2'(gi));
        if (accept && (dest == 2'(gi)))
          data_reg[gi] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      lane_ptr_reg   <= 2'd0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= bus.auto_sel && accept && (lane_ptr_reg == 2'd3);
      if (!bus.auto_sel)
        lane_ptr_reg <= 2'd0;
      else if (accept)
        lane_ptr_reg <= lane_ptr_reg + 2'd1;
    end
  end

  assign bus.data_out0  = data_reg[0];
  assign bus.data_out1  = data_reg[1];
  assign bus.data_out2  = data_reg[2];
  assign bus.data_out3  = data_reg[3];
  assign bus.valid_out0 = valid_reg[0];
  assign bus.valid_out1 = valid_reg[1];
  assign bus.valid_out2 = valid_reg[2];
  assign bus.valid_out3 = valid_reg[3];
  assign bus.lane_ptr   = lane_ptr_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_demux_memoria1x4_4bits.sv
// Directed per-cycle vectors for the registered 1-to-4 demux, plus a hand-written
// back-to-back same-lane sequence.
module tb_demux_memoria1x4_4bits;
  logic clk = 1'b0;
  logic reset_L;

  demux_memoria1x4_4bits_if #(.DATA_W(4)) bus ();

  demux_memoria1x4_4bits #(.DATA_W(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_l;
    logic [1:0]  sel;
    logic        auto_sel;
    logic        valid;
    logic [3:0]  data;
    logic [15:0] exp_data;   // {lane3, lane2, lane1, lane0}
    logic [3:0]  exp_valid;  // bit i = lane i
    logic [1:0]  exp_ptr;
    logic        exp_fd;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fd_count = 0;

  task automatic add(input logic r, input logic [1:0] s, input logic a, input logic v,
                     input logic [3:0] d, input logic [15:0] ed, input logic [3:0] ev,
                     input logic [1:0] ep, input logic ef);
    vec_t t;
    t = '{r, s, a, v, d, ed, ev, ep, ef};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h required %h", name, idx, got, exp);
    end
  endtask

  function automatic logic [15:0] cur_data();
    return {bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0};
  endfunction

  function automatic logic [3:0] cur_valid();
    return {bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0};
  endfunction

  task automatic drive(input logic r, input logic [1:0] s, input logic a, input logic v,
                       input logic [3:0] d);
    reset_L         = r;
    bus.selector    = s;
    bus.auto_sel    = a;
    bus.valid_input = v;
    bus.data_in     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held two edges with a word presented
    add(0, 0, 0, 1, 4'hF, 16'h0000, 4'b0000, 0, 0);
    add(0, 0, 0, 1, 4'hF, 16'h0000, 4'b0000, 0, 0);
    // explicit routing
    add(1, 2, 0, 1, 4'hA, 16'h0A00, 4'b0100, 0, 0);
    add(1, 0, 0, 1, 4'h5, 16'h0A05, 4'b0001, 0, 0);
    add(1, 0, 0, 0, 4'h0, 16'h0A05, 4'b0000, 0, 0);
    // round-robin wrap
    add(1, 0, 1, 1, 4'h1, 16'h0A01, 4'b0001, 1, 0);
    add(1, 0, 1, 1, 4'h2, 16'h0A21, 4'b0010, 2, 0);
    add(1, 0, 1, 1, 4'h3, 16'h0321, 4'b0100, 3, 0);
    add(1, 0, 1, 1, 4'h4, 16'h4321, 4'b1000, 0, 1);
    add(1, 0, 1, 1, 4'h6, 16'h4326, 4'b0001, 1, 0);
    // gaps in auto mode (idle explicit cycle re-zeroes the pointer first)
    add(1, 0, 0, 0, 4'h0, 16'h4326, 4'b0000, 0, 0);
    add(1, 0, 1, 1, 4'h7, 16'h4327, 4'b0001, 1, 0);
    add(1, 0, 1, 0, 4'h0, 16'h4327, 4'b0000, 1, 0);
    add(1, 0, 1, 0, 4'h0, 16'h4327, 4'b0000, 1, 0);
    add(1, 0, 1, 1, 4'h8, 16'h4387, 4'b0010, 2, 0);
    // reset mid-group
    add(1, 0, 0, 0, 4'h0, 16'h4387, 4'b0000, 0, 0);
    add(1, 0, 1, 1, 4'h5, 16'h4385, 4'b0001, 1, 0);
    add(1, 0, 1, 1, 4'h6, 16'h4365, 4'b0010, 2, 0);
    add(0, 0, 1, 1, 4'hF, 16'h0000, 4'b0000, 0, 0);
    add(1, 0, 1, 1, 4'h9, 16'h0009, 4'b0001, 1, 0);
    add(1, 0, 1, 1, 4'hA, 16'h00A9, 4'b0010, 2, 0);
    add(1, 0, 1, 1, 4'hB, 16'h0BA9, 4'b0100, 3, 0);
    add(1, 0, 1, 1, 4'hC, 16'hCBA9, 4'b1000, 0, 1);
    // mode switch with pointer at 2
    add(1, 0, 1, 1, 4'h1, 16'hCBA1, 4'b0001, 1, 0);
    add(1, 0, 1, 1, 4'h2, 16'hCB21, 4'b0010, 2, 0);
    add(1, 3, 0, 1, 4'hE, 16'hEB21, 4'b1000, 0, 0);
    add(1, 0, 1, 1, 4'hD, 16'hEB2D, 4'b0001, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_l, vecs[i].sel, vecs[i].auto_sel, vecs[i].valid, vecs[i].data);
      check("data_out", i, cur_data(), vecs[i].exp_data);
      check("valid_out", i, {12'd0, cur_valid()}, {12'd0, vecs[i].exp_valid});
      check("lane_ptr", i, {14'd0, bus.lane_ptr}, {14'd0, vecs[i].exp_ptr});
      check("frame_done", i, {15'd0, bus.frame_done}, {15'd0, vecs[i].exp_fd});
      check("valid_onehot", i, {15'd0, ($countones(cur_valid()) <= 1)}, 16'd1);
      if (bus.frame_done === 1'b1) fd_count++;
      if (i == 22) begin
        // frames completed so far: wrap group and the post-reset group only
        check("frame_done_count", i, 16'(fd_count), 16'd2);
      end
      $display("step %0d rst_l=%0b auto=%0b sel=%0d valid=%0b din=%h -> data=%h valid=%b ptr=%0d fd=%0b",
               i, vecs[i].rst_l, vecs[i].auto_sel, vecs[i].sel, vecs[i].valid, vecs[i].data,
               cur_data(), cur_valid(), bus.lane_ptr, bus.frame_done);
    end

    // back-to-back writes to the same explicit lane keep its valid high
    drive(1, 1, 0, 1, 4'h3);
    check("b2b_first_data", 100, cur_data(), 16'hEB3D);
    check("b2b_first_valid", 100, {12'd0, cur_valid()}, 16'h0002);
    $display("b2b 1: data=%h valid=%b", cur_data(), cur_valid());
    drive(1, 1, 0, 1, 4'h9);
    check("b2b_second_data", 101, cur_data(), 16'hEB9D);
    check("b2b_second_valid", 101, {12'd0, cur_valid()}, 16'h0002);
    check("b2b_ptr", 101, {14'd0, bus.lane_ptr}, 16'd0);
    $display("b2b 2: data=%h valid=%b", cur_data(), cur_valid());
    drive(1, 1, 0, 0, 4'h0);
    check("b2b_idle_valid", 102, {12'd0, cur_valid()}, 16'h0000);
    check("b2b_idle_data", 102, cur_data(), 16'hEB9D);
    $display("b2b idle: data=%h valid=%b", cur_data(), cur_valid());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
